// File: rtl/fpf_decoder_07_if.sv
// Bus bundle for the 7-wire FPF decoder: codeword in, data word out.
// Upstream drives the master side; the decoder takes the slave side.
`ifndef FBLEN07
`define FBLEN07 6
`endif

interface fpf_decoder_07_if #(
    parameter int ERRCNT_W = 8
);
    logic [6:0]          code_in;
    logic                in_valid;
    logic                in_ready;
    logic [`FBLEN07-1:0] dataout;
    logic                out_valid;
    logic                out_ready;
    logic                fp_err;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output code_in, in_valid, out_ready,
        input  in_ready, dataout, out_valid, fp_err, err_count
    );

    modport slave (
        input  code_in, in_valid, out_ready,
        output in_ready, dataout, out_valid, fp_err, err_count
    );
endinterface

// File: rtl/fpf_decoder_07.sv
// FPF Fibonacci decoder: two-stage elastic pipeline (partial sums, final sum).
// Define FPF_CHECK_EN to add the 010/101 pattern flag and saturating counter.
`ifndef FBLEN07
`define FBLEN07 6
`endif
`ifndef FNS01
`define FNS01 1
`endif
`ifndef FNS02
`define FNS02 1
`endif
`ifndef FNS03
`define FNS03 2
`endif
`ifndef FNS04
`define FNS04 3
`endif
`ifndef FNS05
`define FNS05 5
`endif
`ifndef FNS06
`define FNS06 8
`endif
`ifndef FNS07
`define FNS07 13
`endif

module fpf_decoder_07 #(
    parameter int PIPE_STAGES = 2,
    parameter int ERRCNT_W    = 8
) (
    input logic             clock,
    input logic             reset,
    fpf_decoder_07_if.slave bus
);
    localparam int DW = `FBLEN07;

    if (PIPE_STAGES != 2) begin : g_bad_pipe
        $error("fpf_decoder_07 supports only PIPE_STAGES = 2");
    end

    logic          v1_q, v1_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] hi_q, hi_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] lo_in, hi_in;
    logic          s1_en, s2_en;

    // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
    assign s2_en = !ov_q || bus.out_ready;
    assign s1_en = !v1_q || s2_en;
    assign bus.in_ready = !reset && s1_en;

    assign lo_in = (bus.code_in[0] ? DW'(`FNS01) : '0)
                 + (bus.code_in[1] ? DW'(`FNS02) : '0)
                 + (bus.code_in[2] ? DW'(`FNS03) : '0)
                 + (bus.code_in[3] ? DW'(`FNS04) : '0);
    assign hi_in = (bus.code_in[4] ? DW'(`FNS05) : '0)
                 + (bus.code_in[5] ? DW'(`FNS06) : '0)
                 + (bus.code_in[6] ? DW'(`FNS07) : '0);

    always_comb begin
        v1_d   = v1_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        ov_d   = ov_q;
        dout_d = dout_q;
        if (s1_en) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                lo_d = lo_in;
                hi_d = hi_in;
            end
        end
        if (s2_en) begin
            ov_d = v1_q;
            if (v1_q) begin
                dout_d = lo_q + hi_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q   <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
            ov_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            v1_q   <= v1_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            ov_q   <= ov_d;
            dout_q <= dout_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.dataout   = dout_q;

`ifdef FPF_CHECK_EN
    logic                flag_in;
    logic                f1_q, f1_d;
    logic                fe_q, fe_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;

    // A triple alternates (010 or 101) when each bit differs from its neighbour.
    always_comb begin
        flag_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.code_in[i] != bus.code_in[i+1] &&
                bus.code_in[i+1] != bus.code_in[i+2]) begin
                flag_in = 1'b1;
            end
        end
    end

    always_comb begin
        f1_d  = f1_q;
        fe_d  = fe_q;
        cnt_d = cnt_q;
        if (s1_en && bus.in_valid) begin
            f1_d = flag_in;
        end
        if (s2_en && v1_q) begin
            fe_d = f1_q;
        end
        if (ov_q && bus.out_ready && fe_q && cnt_q != '1) begin
            cnt_d = cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            f1_q  <= 1'b0;
            fe_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            f1_q  <= f1_d;
            fe_q  <= fe_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.fp_err    = fe_q;
    assign bus.err_count = cnt_q;
`else
    assign bus.fp_err    = 1'b0;
    assign bus.err_count = {ERRCNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fpf_decoder_07.sv
// Scoreboard bench for fpf_decoder_07: directed cases, FPF sweep, random traffic.
// Expected words come from a Fibonacci weight table, not from the pipeline.
`ifndef FBLEN07
`define FBLEN07 6
`endif

module tb_fpf_decoder_07;
    logic clock = 1'b0;
    logic reset = 1'b1;

    fpf_decoder_07_if #(.ERRCNT_W(8)) bus ();

    fpf_decoder_07 #(
        .PIPE_STAGES(2),
        .ERRCNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int data;
        bit flag;
        int cyc;
        bit lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   err_model = 0;
    bit   chk_lat = 0;
    bit   rand_ready = 0;
    bit   saw_stall = 0;
    bit   hold_prev = 0;
    bit   rst_prev = 0;
    int   held_d;
    bit   held_e;
    int   W[7] = '{1, 1, 2, 3, 5, 8, 13};

    function automatic int ref_val(input logic [6:0] c);
        int s = 0;
        for (int i = 0; i < 7; i++) if (c[i]) s += W[i];
        return s;
    endfunction

    function automatic bit ref_flag(input logic [6:0] c);
        for (int i = 0; i < 5; i++)
            if (c[i] != c[i+1] && c[i+1] != c[i+2]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: checks every cycle, pops on each output transfer.
    exp_t e;
    bit   exp_rdy;
    always @(negedge clock) begin
        if (rst_prev) begin
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_dataout", int'(bus.dataout), 0);
            chk("rst_fp_err", int'(bus.fp_err), 0);
            chk("rst_err_count", int'(bus.err_count), 0);
        end
        if (hold_prev) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.dataout), held_d);
            chk("hold_fp_err", int'(bus.fp_err), int'(held_e));
        end
        exp_rdy = !reset && !(q.size() == 2 && !bus.out_ready);
        chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
        if (!reset && !bus.in_ready) saw_stall = 1'b1;
`ifdef FPF_CHECK_EN
        chk("err_count", int'(bus.err_count), err_model);
`else
        chk("err_count_off", int'(bus.err_count), 0);
        chk("fp_err_off", int'(bus.fp_err), 0);
`endif
        if (reset) begin
            q.delete();
            err_model = 0;
            hold_prev = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", int'(bus.dataout), -1);
                end else begin
                    e = q.pop_front();
                    chk("dataout", int'(bus.dataout), e.data);
`ifdef FPF_CHECK_EN
                    chk("fp_err", int'(bus.fp_err), int'(e.flag));
                    if (e.flag && err_model < 255) err_model++;
`endif
                    if (chk_lat && e.lat) chk("latency", cyc - e.cyc, 2);
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held_d    = int'(bus.dataout);
            held_e    = bus.fp_err;
            if (bus.in_valid && bus.in_ready) begin
                e.data = ref_val(bus.code_in);
                e.flag = ref_flag(bus.code_in);
                e.cyc  = cyc;
                e.lat  = chk_lat;
                q.push_back(e);
            end
        end
        rst_prev = reset;
    end

    task automatic send(input logic [6:0] c);
        int n = 0;
        bus.code_in  = c;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.in_ready && n < 1000);
        if (!bus.in_ready) chk("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_left", q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.code_in   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk_lat = 1'b1;
        send(7'b0000000);
        drain();

        send(7'b1111111);
        send(7'b1100000);
        send(7'b0011100);
        send(7'b0000001);
        drain();

        chk_lat   = 1'b0;
        saw_stall = 1'b0;
        fork
            begin
                send(7'b1000001);
                send(7'b0100011);
                send(7'b0001111);
                send(7'b1110000);
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_seen", int'(saw_stall), 1);

        bus.out_ready = 1'b0;
        send(7'b1111000);
        send(7'b0000110);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        send(7'b0011100);
        drain();

        for (int c = 0; c < 128; c++) begin
            if (!ref_flag(7'(c))) send(7'(c));
        end
        drain();

        chk_lat    = 1'b0;
        rand_ready = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            send(7'($urandom_range(0, 127)));
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;

`ifdef FPF_CHECK_EN
        chk_lat = 1'b1;
        send(7'b0101100);
        send(7'b0011100);
        drain();
        repeat (300) send(7'b0101100);
        drain();
        chk("err_saturated", int'(bus.err_count), 255);
`endif

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
